ahb_rr_master_arbiter: RTL

- Round-robin arbiter/sequencer that lets NUM_REQ local requesters share one AHB-Lite master port driving ahb_to_apb_bridge.
- Each requester presents a single-word read/write request. The arbiter picks one winner, runs one NONSEQ address phase and one data phase on the AHB side, then returns read data and status to the winner.
- Sits between CPU-side agents (DMA, debug, config) and the bridge slave port. Issues single transfers only; no bursts, no pipelining of consecutive transfers.

---
 rtl/ahb_rr_master_arbiter_if.sv | 27 ++
 rtl/ahb_rr_master_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_master_arbiter_if.sv
// AHB-Lite signal bundle between the round-robin master sequencer and a
// single slave port (the AHB-to-APB bridge). Names follow AHB so waveforms
// read naturally against the bridge.
interface ahb_rr_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [1:0]            HTRANS;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY_IN;
    logic                  HREADY_OUT;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HRESP;

    modport master (
        output HSEL, HTRANS, HADDR, HWRITE, HWDATA, HREADY_IN,
        input  HREADY_OUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HTRANS, HADDR, HWRITE, HWDATA, HREADY_IN,
        output HREADY_OUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_rr_master_arbiter.sv
// Round-robin sequencer letting NUM_REQ single-word requesters share one
// AHB-Lite master port. One transfer in flight at a time:
// IDLE (arbitrate, latch winner) -> ADDR (NONSEQ) -> DATA (complete, respond).
module ahb_rr_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            rsp_done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    ahb_rr_master_arbiter_if.master       ahb
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    rsp_done_q, rsp_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  hready_in_q;

    logic [NUM_REQ-1:0]    eligible;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W:0]        cand_w;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // A requester whose done pulse is out this cycle is masked so it cannot
    // immediately win again while it is still dropping req.
    assign eligible = req & ~rsp_done_q;

    // Round-robin search: first eligible index after last_q, wrapping exactly
    // at NUM_REQ so non-power-of-two counts rotate correctly.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the block can leave a value held and infer a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_w     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_w = {1'b0, last_q} + (IDX_W+1)'(k);
            if (cand_w >= (IDX_W+1)'(NUM_REQ)) begin
                cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_valid && eligible[cand_w[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_w[IDX_W-1:0];
            end
        end
    end

    // Next-state and response logic for the IDLE/ADDR/DATA sequencer.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        grant_d     = grant_q;
        rsp_done_d  = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d             = pick_idx;
                    addr_d            = addr_arr[pick_idx];
                    write_d           = req_write[pick_idx];
                    wdata_d           = wdata_arr[pick_idx];
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = ADDR;
                end
            end
            ADDR: begin
                if (ahb.HREADY_OUT) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ahb.HREADY_OUT) begin
                    rsp_rdata_d       = write_q ? '0 : ahb.HRDATA;
                    rsp_err_d         = ahb.HRESP;
                    rsp_done_d[win_q] = 1'b1;
                    grant_d           = '0;
                    last_d            = win_q;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-transfer registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // pre-edge values regardless of statement order.
        if (HRESET) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            win_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            grant_q     <= '0;
            rsp_done_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            grant_q     <= grant_d;
            rsp_done_q  <= rsp_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // HREADY_IN is held low only while reset is applied; the sequencer never
    // pipelines, so otherwise the bus is always ready.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hready_in_q <= 1'b0;
        end else begin
            hready_in_q <= 1'b1;
        end
    end

    assign grant     = grant_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // AHB outputs decode from state: address phase only in ADDR, write data
    // only in DATA, zeros elsewhere.
    assign ahb.HSEL      = (state_q == ADDR);
    assign ahb.HTRANS    = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign ahb.HADDR     = (state_q == ADDR) ? addr_q : '0;
    assign ahb.HWRITE    = (state_q == ADDR) ? write_q : 1'b0;
    assign ahb.HWDATA    = (state_q == DATA) ? wdata_q : '0;
    assign ahb.HREADY_IN = hready_in_q;
endmodule
